// File: rtl/inst_mem_loader.sv
// inst_mem_loader
// ----------------
// Write-side companion to the instruction memory. A host or boot link streams
// program bytes in. The loader packs each group of four bytes into a
// little-endian 32-bit instruction. It then issues one word write per
// instruction at byte addresses 0, 4, 8, ... While an image is loading, the
// loader holds the CPU pipeline in reset.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   start       one-cycle pulse that begins a load (honoured in IDLE/DONE)
//   byte_valid  host presents byte_data
//   byte_data   program byte
//   byte_last   final byte of the image, qualified by byte_valid
//   byte_ready  loader accepts a byte this cycle
//   mem_we      instruction memory write enable (one-cycle pulse)
//   mem_addr    byte address of the write, multiple of 4
//   mem_wdata   assembled instruction
//   cpu_hold    keeps the pipeline in reset while loading
//   done        load finished, held at level
//   error       sticky: partial final word or capacity overflow
//   word_count  words written in the current load
//   state_dbg   current FSM state (IDLE=0, RECV=1, WRITE=2, DONE=3)
//
// Byte handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both high. byte_data and byte_last are only meaningful while
// byte_valid is high. byte_ready is registered. It is high only in RECV, so a
// host may hold byte_valid high across WRITE cycles without losing or
// duplicating a byte.

module inst_mem_loader #(
   parameter int MAX_WORDS = 100,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   input  logic             byte_last,
   output logic             byte_ready,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             cpu_hold,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] word_count,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state;
   logic [1:0]  byte_idx;
   logic [31:0] asm_word;
   logic        last_seen;

   logic        accept;
   logic        word_end;
   logic        room;
   logic [31:0] asm_next;

   assign state_dbg = state;

   always_comb begin
      accept   = (state == S_RECV) && byte_valid && byte_ready;
      word_end = accept && ((byte_idx == 2'd3) || byte_last);
      // Capacity test against the count before this word's increment.
      room     = word_count < CNT_W'(MAX_WORDS);
      // The assembly register is zero at the start of every word, so a short
      // final word is zero-filled in its upper lanes automatically.
      asm_next = asm_word;
      case (byte_idx)
         2'd0:    asm_next[7:0]   = byte_data;
         2'd1:    asm_next[15:8]  = byte_data;
         2'd2:    asm_next[23:16] = byte_data;
         default: asm_next[31:24] = byte_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         byte_idx   <= 2'd0;
         asm_word   <= 32'd0;
         last_seen  <= 1'b0;
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         cpu_hold   <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state      <= S_RECV;
                  byte_ready <= 1'b1;
                  cpu_hold   <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  word_count <= '0;
                  byte_idx   <= 2'd0;
                  asm_word   <= 32'd0;
                  last_seen  <= 1'b0;
               end
            end

            S_RECV: begin
               if (accept) begin
                  asm_word  <= asm_next;
                  byte_idx  <= byte_idx + 2'd1;
                  last_seen <= byte_last;
                  if (word_end) begin
                     state      <= S_WRITE;
                     byte_ready <= 1'b0;
                     if (byte_last && (byte_idx != 2'd3)) begin
                        error <= 1'b1;
                     end
                     // Write strobe and data are launched on the handshake
                     // edge so the write lands in the WRITE cycle itself.
                     if (room) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= 32'(word_count) << 2;
                        mem_wdata <= asm_next;
                     end
                  end
               end
            end

            S_WRITE: begin
               byte_idx <= 2'd0;
               asm_word <= 32'd0;
               if (!room) begin
                  // Memory full: the word is dropped and the load ends.
                  error    <= 1'b1;
                  state    <= S_DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
               end else begin
                  word_count <= word_count + CNT_W'(1);
                  if (last_seen) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state      <= S_RECV;
                     byte_ready <= 1'b1;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
